// File: rtl/hazard_ctrl_if.sv
// Bundle of the hazard controller's pipeline-side signals: ID/EXE/MEM
// operand information, branch and memory status in, and sequencing
// controls, status and the stall counter out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_src1;
    logic [4:0]       ID_src2;
    logic             ID_two_src;
    logic             ID_valid;
    logic [4:0]       EXE_dest;
    logic             EXE_WB_en;
    logic             EXE_MEM_R_en;
    logic [4:0]       MEM_dest;
    logic             MEM_WB_en;
    logic             fwd_en;
    logic             Br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_freeze;
    logic             ifid_freeze;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_freeze;
    logic             mem_err;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: drives hazard information, receives the controls.
    modport master (
        output ID_src1, ID_src2, ID_two_src, ID_valid,
               EXE_dest, EXE_WB_en, EXE_MEM_R_en,
               MEM_dest, MEM_WB_en, fwd_en, Br_taken,
               mem_req, mem_ready,
        input  pc_freeze, ifid_freeze, ifid_flush, idex_bubble,
               pipe_freeze, mem_err, state, stall_cnt
    );

    // Controller side.
    modport slave (
        input  ID_src1, ID_src2, ID_two_src, ID_valid,
               EXE_dest, EXE_WB_en, EXE_MEM_R_en,
               MEM_dest, MEM_WB_en, fwd_en, Br_taken,
               mem_req, mem_ready,
        output pc_freeze, ifid_freeze, ifid_flush, idex_bubble,
               pipe_freeze, mem_err, state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage MIPS core: load-use/RAW
// stalls, taken-branch flushes, data-memory wait freezes, a memory-timeout
// watchdog and a saturating stall counter. Controls are combinational.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    hazard_ctrl_if.slave      bus
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    localparam int WW = $clog2(TIMEOUT) + 1;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WW-1:0]    wait_cnt;
    logic [CNT_W-1:0] stall_cnt_q;

    logic hz_exe;
    logic hz_mem;
    logic raw;
    logic mem_stall;
    logic timeout_hit;

    logic pc_f;
    logic ifid_f;
    logic flush;
    logic bubble;
    logic pipe_f;
    logic err;

    // Hazard detection against the instructions in EXE and MEM.
    always_comb begin
        hz_exe = bus.EXE_WB_en && (bus.EXE_dest != 5'd0) &&
                 ((bus.EXE_dest == bus.ID_src1) ||
                  (bus.ID_two_src && (bus.EXE_dest == bus.ID_src2)));
        hz_mem = bus.MEM_WB_en && (bus.MEM_dest != 5'd0) &&
                 ((bus.MEM_dest == bus.ID_src1) ||
                  (bus.ID_two_src && (bus.MEM_dest == bus.ID_src2)));
        raw = bus.ID_valid &&
              (bus.fwd_en ? (hz_exe && bus.EXE_MEM_R_en) : (hz_exe || hz_mem));
        mem_stall   = bus.mem_req && !bus.mem_ready;
        timeout_hit = mem_stall && (wait_cnt == WW'(TIMEOUT - 1));
    end

    // Prioritised control outputs: memory wait, then branch flush, then RAW.
    always_comb begin
        pc_f   = 1'b0;
        ifid_f = 1'b0;
        flush  = 1'b0;
        bubble = 1'b0;
        pipe_f = 1'b0;
        err    = 1'b0;
        if (!rst) begin
            if (state_q == ERROR) begin
                pc_f   = 1'b1;
                ifid_f = 1'b1;
                pipe_f = 1'b1;
                err    = 1'b1;
            end else if (mem_stall) begin
                pc_f   = 1'b1;
                ifid_f = 1'b1;
                pipe_f = 1'b1;
            end else if (bus.Br_taken) begin
                flush  = 1'b1;
                bubble = 1'b1;
            end else if (raw) begin
                pc_f   = 1'b1;
                ifid_f = 1'b1;
                bubble = 1'b1;
            end
        end
    end

    // Next-state selection; ERROR is only left through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (timeout_hit)    state_d = ERROR;
                else if (mem_stall) state_d = MEM_WAIT;
                else                state_d = RUN;
            end
            ERROR:   state_d = ERROR;
            default: state_d = RUN;
        endcase
    end

    // State register and consecutive-stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q != ERROR) begin
                wait_cnt <= mem_stall ? wait_cnt + 1'b1 : '0;
            end
        end
    end

    // Saturating count of non-ERROR cycles with the PC held.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q != ERROR) && pc_f && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.pc_freeze   = pc_f;
    assign bus.ifid_freeze = ifid_f;
    assign bus.ifid_flush  = flush;
    assign bus.idex_bubble = bubble;
    assign bus.pipe_freeze = pipe_f;
    assign bus.mem_err     = err;
    assign bus.state       = state_q;
    assign bus.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (TIMEOUT=4/CNT_W=4 and
// the 16/16 defaults) share one stimulus stream and are compared every cycle
// against a behavioural model, after a directed sequence with literal checks.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] src1, src2, edst, mdst;
    logic two, vld, ewb, eld, mwb, fwd, br, req, rdy;

    hazard_ctrl_if #(.CNT_W(4))  ia ();
    hazard_ctrl_if #(.CNT_W(16)) ib ();

    assign ia.ID_src1 = src1;     assign ib.ID_src1 = src1;
    assign ia.ID_src2 = src2;     assign ib.ID_src2 = src2;
    assign ia.ID_two_src = two;   assign ib.ID_two_src = two;
    assign ia.ID_valid = vld;     assign ib.ID_valid = vld;
    assign ia.EXE_dest = edst;    assign ib.EXE_dest = edst;
    assign ia.EXE_WB_en = ewb;    assign ib.EXE_WB_en = ewb;
    assign ia.EXE_MEM_R_en = eld; assign ib.EXE_MEM_R_en = eld;
    assign ia.MEM_dest = mdst;    assign ib.MEM_dest = mdst;
    assign ia.MEM_WB_en = mwb;    assign ib.MEM_WB_en = mwb;
    assign ia.fwd_en = fwd;       assign ib.fwd_en = fwd;
    assign ia.Br_taken = br;      assign ib.Br_taken = br;
    assign ia.mem_req = req;      assign ib.mem_req = req;
    assign ia.mem_ready = rdy;    assign ib.mem_ready = rdy;

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int TO[2]   = '{4, 16};
    localparam int MAXC[2] = '{15, 65535};
    bit m_err[2];
    bit m_last[2];
    int m_run[2];
    int m_cnt[2];

    function automatic bit hit(input logic [4:0] d, input logic wb);
        return wb && d != 0 && (d == src1 || (two && d == src2));
    endfunction

    function automatic bit m_stall();
        return req && !rdy;
    endfunction

    function automatic bit m_raw();
        if (!vld) return 0;
        if (fwd) return hit(edst, ewb) && eld;
        return hit(edst, ewb) || hit(mdst, mwb);
    endfunction

    // {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze, mem_err}
    function automatic logic [5:0] m_ctrl(input int k);
        if (rst) return 6'b0;
        if (m_err[k]) return 6'b110011;
        if (m_stall()) return 6'b110010;
        if (br) return 6'b001100;
        if (m_raw()) return 6'b110100;
        return 6'b0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_err[k]  <= 0;
                m_last[k] <= 0;
                m_run[k]  <= 0;
                m_cnt[k]  <= 0;
            end else if (!m_err[k]) begin
                if (m_stall()) begin
                    if (m_run[k] + 1 >= TO[k]) m_err[k] <= 1;
                    m_run[k]  <= m_run[k] + 1;
                    m_last[k] <= 1;
                end else begin
                    m_run[k]  <= 0;
                    m_last[k] <= 0;
                end
                if (m_ctrl(k)[5] && m_cnt[k] < MAXC[k]) m_cnt[k] <= m_cnt[k] + 1;
            end
        end
    end

    // Compare process: outputs settle mid-cycle, sampled on the falling edge.
    always @(negedge clk) begin
        logic [5:0]  act_c[2];
        logic [1:0]  act_s[2];
        logic [15:0] act_n[2];
        act_c[0] = {ia.pc_freeze, ia.ifid_freeze, ia.ifid_flush, ia.idex_bubble, ia.pipe_freeze, ia.mem_err};
        act_c[1] = {ib.pc_freeze, ib.ifid_freeze, ib.ifid_flush, ib.idex_bubble, ib.pipe_freeze, ib.mem_err};
        act_s[0] = ia.state;
        act_s[1] = ib.state;
        act_n[0] = 16'(ia.stall_cnt);
        act_n[1] = ib.stall_cnt;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_ctrl[%0d]", k), 32'(act_c[k]), 32'(m_ctrl(k)));
            if (!rst) begin
                chk($sformatf("model_state[%0d]", k), 32'(act_s[k]),
                    m_err[k] ? 32'd2 : (m_last[k] ? 32'd1 : 32'd0));
                chk($sformatf("model_cnt[%0d]", k), 32'(act_n[k]), 32'(m_cnt[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        src1 = 0; src2 = 0; edst = 0; mdst = 0;
        two = 0; vld = 0; ewb = 0; eld = 0; mwb = 0; fwd = 0; br = 0; req = 0; rdy = 0;
    endtask

    // Apply inputs for the next cycle, then wait until its outputs are settled.
    task automatic next();
        @(negedge clk);
    endtask

    task automatic start();
        @(posedge clk);
        #1;
    endtask

    task automatic loaduse();
        idle();
        fwd = 1; ewb = 1; eld = 1; edst = 5; src1 = 5; vld = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        start(); start();
        next();
        chk("reset_ctrl", 32'({ia.pc_freeze, ia.ifid_flush, ia.idex_bubble, ia.pipe_freeze}), 32'd0);

        start(); rst = 0; idle(); next();
        chk("reset_state", 32'(ia.state), 32'd0);
        chk("reset_cnt", 32'(ib.stall_cnt), 32'd0);

        start(); loaduse(); next();
        chk("loaduse", 32'({ib.pc_freeze, ib.ifid_freeze, ib.idex_bubble, ib.pipe_freeze}), 32'b1110);
        start(); idle(); next();
        chk("loaduse_cnt", 32'(ib.stall_cnt), 32'd1);
        chk("loaduse_one_cycle", 32'(ib.pc_freeze), 32'd0);

        start(); idle(); mwb = 1; mdst = 7; two = 1; src2 = 7; src1 = 3; vld = 1; next();
        chk("nofwd_src2", 32'(ib.pc_freeze), 32'd1);
        start(); two = 0; next();
        chk("nofwd_one_src", 32'(ib.pc_freeze), 32'd0);
        start(); two = 1; mdst = 0; src2 = 0; next();
        chk("nofwd_r0", 32'(ib.pc_freeze), 32'd0);

        start(); loaduse(); br = 1; next();
        chk("branch", 32'({ib.ifid_flush, ib.idex_bubble, ib.pc_freeze}), 32'b110);
        start(); idle(); next();
        chk("cnt_after_branch", 32'(ib.stall_cnt), 32'd2);

        for (int i = 0; i < 5; i++) begin
            start(); idle();
            req = (i < 4); rdy = (i == 3);
            next();
            chk($sformatf("memwait_state%0d", i), 32'(ib.state), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("memwait_freeze%0d", i), 32'(ib.pipe_freeze), (i < 3) ? 32'd1 : 32'd0);
        end
        chk("memwait_cnt", 32'(ib.stall_cnt), 32'd5);

        for (int i = 0; i < 5; i++) begin
            start(); idle(); req = 1; rdy = (i == 4); next();
        end
        chk("wdog_state", 32'(ia.state), 32'd2);
        chk("wdog_err_sticky", 32'(ia.mem_err), 32'd1);
        chk("wdog_b_wait", 32'(ib.state), 32'd1);
        chk("wdog_cnt_frozen", 32'(ia.stall_cnt), 32'd9);
        start(); rst = 1; idle(); next();
        chk("rst_err_forced", 32'(ia.mem_err), 32'd0);
        start(); rst = 0; next();
        chk("rst_state", 32'(ia.state), 32'd0);
        chk("rst_err", 32'(ia.mem_err), 32'd0);

        for (int i = 0; i < 20; i++) begin
            start(); loaduse(); next();
        end
        start(); idle(); next();
        chk("sat_cnt", 32'(ia.stall_cnt), 32'd15);
        chk("nosat_cnt", 32'(ib.stall_cnt), 32'd20);

        for (int i = 0; i < 4000; i++) begin
            start();
            rst  = ($urandom_range(0, 79) == 0);
            src1 = 5'($urandom_range(0, 7));
            src2 = 5'($urandom_range(0, 7));
            edst = 5'($urandom_range(0, 7));
            mdst = 5'($urandom_range(0, 7));
            two  = 1'($urandom); vld = 1'($urandom);
            ewb  = 1'($urandom); eld = 1'($urandom); mwb = 1'($urandom);
            fwd  = 1'($urandom); br  = ($urandom_range(0, 3) == 0);
            req  = 1'($urandom); rdy = ($urandom_range(0, 2) == 0);
            next();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
